// File: rtl/bias_loader.sv
// -----------------------------------------------------------------------------
// bias_loader
//
// Purpose:
//   Collects NUM_FEATURES+1 signed bias words from a serial valid/ready
//   stream, index 0 first, into a parallel vector. When the vector is
//   complete it strobes the bias memory write enable (active low) for one
//   full clock cycle. It then returns to idle and pulses done.
//
// Optional feature (macro BIAS_LOADER_CHECKSUM_EN):
//   When defined, the loader keeps an additive checksum (modulo
//   2^DATA_WIDTH) of the accepted words. After the last bias word it
//   accepts one extra word, which is the expected sum. On a match the
//   vector is committed. On a mismatch the loader returns to idle with an
//   err pulse and does not commit. When the macro is undefined there is no
//   CHECK state and no accumulator, and err is tied to 0.
//
// Ports:
//   clk               clock, all state updates on posedge
//   rst               asynchronous, active-low reset
//   start             begin a load sequence (sampled only in IDLE)
//   in_valid/in_data  serial bias word stream
//   in_ready          loader accepts in_data this cycle (LOAD/CHECK)
//   bias_weights_out  assembled bias vector, NUM_FEATURES+1 words
//   bias_WrEn         active-low write strobe, low for exactly COMMIT
//   busy              high in any state except IDLE
//   done              one-cycle pulse in the first IDLE cycle after COMMIT
//   err               one-cycle pulse on checksum mismatch
// -----------------------------------------------------------------------------
module bias_loader #(
  parameter int NUM_FEATURES = 3,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH-1:0] bias_weights_out [NUM_FEATURES+1],
  output logic                         bias_WrEn,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int NUM_WORDS = NUM_FEATURES + 1;
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES);

`ifdef BIAS_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
`endif

  state_t                         state_q, state_d;
  logic   [IDX_W-1:0]             idx_q;
  logic                           in_ready_q;
  logic                           busy_q;
  logic                           wren_q;
  logic                           done_q;
  logic signed [DATA_WIDTH-1:0]   bias_q [NUM_WORDS];
  logic                           accept;

`ifdef BIAS_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]          sum_q;
  logic                           err_q;
  logic                           csum_match;

  assign csum_match = ($unsigned(in_data) == sum_q);
`endif

  // A bias word lands in the vector only while collecting; the checksum
  // word taken in CHECK never touches the array.
  assign accept = (state_q == LOAD) && in_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = LOAD;
      LOAD: begin
        if (in_valid && (idx_q == LAST_IDX)) begin
`ifdef BIAS_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = COMMIT;
`endif
        end
      end
`ifdef BIAS_LOADER_CHECKSUM_EN
      CHECK:  if (in_valid) state_d = csum_match ? COMMIT : IDLE;
`endif
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so each one lines up
  // exactly with the state it describes and has no combinational glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      wren_q     <= 1'b1;
      done_q     <= 1'b0;
`ifdef BIAS_LOADER_CHECKSUM_EN
      sum_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      busy_q     <= (state_d != IDLE);
      wren_q     <= (state_d != COMMIT);
      // COMMIT always falls through to IDLE, so done marks that first IDLE cycle.
      done_q     <= (state_q == COMMIT);
`ifdef BIAS_LOADER_CHECKSUM_EN
      in_ready_q <= (state_d == LOAD) || (state_d == CHECK);
      err_q      <= (state_q == CHECK) && in_valid && !csum_match;
      if ((state_q == IDLE) && start) begin
        sum_q <= '0;
      end else if (accept) begin
        sum_q <= sum_q + $unsigned(in_data);
      end
`else
      in_ready_q <= (state_d == LOAD);
`endif
      // The index saturates at the last word instead of wrapping.
      if ((state_q == IDLE) && start) begin
        idx_q <= '0;
      end else if (accept && (idx_q != LAST_IDX)) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  // One register per vector word. A word changes only when its own index
  // is written, so the vector is stable from the last accepted word
  // through COMMIT. It also holds its contents while idle.
  generate
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          bias_q[gi] <= '0;
        end else if (accept && (idx_q == IDX_W'(gi))) begin
          bias_q[gi] <= in_data;
        end
      end
      assign bias_weights_out[gi] = bias_q[gi];
    end
  endgenerate

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign bias_WrEn = wren_q;
  assign done      = done_q;
`ifdef BIAS_LOADER_CHECKSUM_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_bias_loader.sv
// -----------------------------------------------------------------------------
// tb_bias_loader
//
// Self-checking bench for bias_loader (NUM_FEATURES=3, DATA_WIDTH=8).
// Expected commit vectors are pushed to a queue when a load is driven. A
// monitor pops and compares one vector each time bias_WrEn goes low. The
// scenario tasks check reset values, pulse counts and timing inline. The
// checksum scenarios run when BIAS_LOADER_CHECKSUM_EN is defined.
// -----------------------------------------------------------------------------
module tb_bias_loader;

  localparam int NF = 3;
  localparam int DW = 8;
  localparam int NW = NF + 1;

  typedef logic signed [DW-1:0] word_t;
  typedef logic [NW*DW-1:0]     vec_t;

  logic  clk;
  logic  rst;
  logic  start;
  logic  in_valid;
  word_t in_data;
  logic  in_ready;
  word_t bias_out [NW];
  logic  bias_WrEn;
  logic  busy;
  logic  done;
  logic  err;

  bias_loader #(.NUM_FEATURES(NF), .DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_ready         (in_ready),
    .bias_weights_out (bias_out),
    .bias_WrEn        (bias_WrEn),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks   = 0;
  int   n_fail     = 0;
  int   done_cnt   = 0;
  int   err_cnt    = 0;
  int   commit_cnt = 0;
  vec_t exp_q [$];
  logic prev_wr_low = 1'b0;

  function automatic vec_t pack4(input word_t w0, input word_t w1, input word_t w2, input word_t w3);
    return {w3, w2, w1, w0};
  endfunction

  function automatic vec_t dut_vec();
    vec_t v;
    for (int i = 0; i < NW; i++) v[i*DW +: DW] = bias_out[i];
    return v;
  endfunction

  // Scoreboard monitor: every cycle with bias_WrEn low is one commit.
  always @(negedge clk) begin
    vec_t got;
    vec_t exp_v;
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
    if (bias_WrEn === 1'b0) begin
      commit_cnt++;
      got = dut_vec();
      n_checks++;
      if (prev_wr_low) begin
        n_fail++;
        $display("FAIL wren_width: bias_WrEn low for consecutive cycles, required exactly one");
      end
      n_checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL commit_flags: in_ready=%b busy=%b, required in_ready=0 busy=1", in_ready, busy);
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_commit: vector=%h, required no commit", got);
      end else begin
        exp_v = exp_q.pop_front();
        if (got !== exp_v) begin
          n_fail++;
          $display("FAIL commit_vector: got %h, required %h", got, exp_v);
        end else begin
          $display("commit vector=%h", got);
        end
      end
    end
    prev_wr_low = (bias_WrEn === 1'b0);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_word(input word_t w);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (in_ready !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    n_checks++;
    if (guard >= 20) begin
      n_fail++;
      $display("FAIL send_word_timeout: in_ready=%b after 20 cycles, required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic send_words(input vec_t wv, input int from, input int gap);
    for (int i = from; i < NW; i++) begin
      send_word(wv[i*DW +: DW]);
      if (i < NW - 1) repeat (gap) tick();
    end
  endtask

`ifdef BIAS_LOADER_CHECKSUM_EN
  task automatic send_csum(input vec_t wv, input int gap, input bit good);
    word_t s = '0;
    for (int i = 0; i < NW; i++) s = s + word_t'(wv[i*DW +: DW]);
    if (!good) s = s + 8'sd1;
    repeat (gap) tick();
    send_word(s);
  endtask
`endif

  task automatic send_load(input vec_t wv, input int gap, input bit good);
    if (good) exp_q.push_back(wv);
    $display("load words=%h gap=%0d good=%0d", wv, gap, good);
    start = 1'b1;
    tick();
    start = 1'b0;
    send_words(wv, 0, gap);
`ifdef BIAS_LOADER_CHECKSUM_EN
    send_csum(wv, gap, good);
`endif
  endtask

  task automatic wait_done();
    int guard = 0;
    while (done !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    n_checks++;
    if (guard >= 20) begin
      n_fail++;
      $display("FAIL done_timeout: done=%b after 20 cycles, required 1", done);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bias_WrEn !== 1'b1) begin n_fail++; $display("FAIL reset_wren: got %b, required 1", bias_WrEn); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_checks++;
    if (done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: done=%b err=%b, required 0 0", done, err); end
    n_checks++;
    if (dut_vec() !== '0) begin n_fail++; $display("FAIL reset_array: got %h, required 0", dut_vec()); end
    $display("reset checked");
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    int c0 = commit_cnt;
    send_load(pack4(8'sd5, -8'sd3, 8'sd7, 8'sd127), 0, 1'b1);
    wait_done();
    tick();
    n_checks++;
    if (done_cnt - d0 != 1 || commit_cnt - c0 != 1) begin
      n_fail++;
      $display("FAIL b2b_counts: done=%0d commits=%0d, required 1 1", done_cnt - d0, commit_cnt - c0);
    end
    n_checks++;
    if (busy !== 1'b0 || dut_vec() !== pack4(8'sd5, -8'sd3, 8'sd7, 8'sd127)) begin
      n_fail++;
      $display("FAIL b2b_idle_hold: busy=%b vec=%h, required 0 %h", busy, dut_vec(), pack4(8'sd5, -8'sd3, 8'sd7, 8'sd127));
    end
  endtask

  task automatic test_bubbles();
    int d0 = done_cnt;
    int c0 = commit_cnt;
    send_load(pack4(8'sd5, -8'sd3, 8'sd7, 8'sd127), 2, 1'b1);
    wait_done();
    repeat (3) tick();
    n_checks++;
    if (done_cnt - d0 != 1 || commit_cnt - c0 != 1) begin
      n_fail++;
      $display("FAIL bubble_counts: done=%0d commits=%0d, required 1 1", done_cnt - d0, commit_cnt - c0);
    end
  endtask

  task automatic test_midload_reset();
    int c0 = commit_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    send_word(8'sd9);
    send_word(-8'sd4);
    rst = 1'b0;
    #1;
    n_checks++;
    if (dut_vec() !== '0) begin n_fail++; $display("FAIL midreset_array: got %h, required 0", dut_vec()); end
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || bias_WrEn !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_flags: busy=%b in_ready=%b wren=%b, required 0 0 1", busy, in_ready, bias_WrEn);
    end
    tick();
    tick();
    rst = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (commit_cnt != c0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_no_commit: commits=%0d busy=%b, required 0 0", commit_cnt - c0, busy);
    end
    send_load(pack4(8'sd1, 8'sd2, 8'sd3, 8'sd4), 0, 1'b1);
    wait_done();
    tick();
  endtask

  task automatic test_start_during_load();
    vec_t wv = pack4(8'sd10, 8'sd20, -8'sd30, 8'sd40);
    exp_q.push_back(wv);
    $display("load words=%h with start pulsed mid-load", wv);
    start = 1'b1;
    tick();
    start = 1'b0;
    send_word(wv[0 +: DW]);
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_in_load: in_ready=%b busy=%b, required 1 1", in_ready, busy);
    end
    send_words(wv, 1, 0);
`ifdef BIAS_LOADER_CHECKSUM_EN
    send_csum(wv, 0, 1'b1);
`endif
    wait_done();
    tick();
  endtask

  task automatic test_start_held();
    vec_t wa = pack4(-8'sd1, -8'sd2, -8'sd128, 8'sd64);
    vec_t wb = pack4(8'sd11, 8'sd22, 8'sd33, 8'sd44);
    int   c0 = commit_cnt;
    exp_q.push_back(wa);
    exp_q.push_back(wb);
    $display("load words=%h then %h with start held", wa, wb);
    start = 1'b1;
    tick();
    send_words(wa, 0, 0);
`ifdef BIAS_LOADER_CHECKSUM_EN
    send_csum(wa, 0, 1'b1);
`endif
    wait_done();
    tick();
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL held_restart: busy=%b in_ready=%b, required 1 1", busy, in_ready);
    end
    start = 1'b0;
    send_words(wb, 0, 0);
`ifdef BIAS_LOADER_CHECKSUM_EN
    send_csum(wb, 0, 1'b1);
`endif
    wait_done();
    tick();
    n_checks++;
    if (commit_cnt - c0 != 2) begin
      n_fail++;
      $display("FAIL held_commits: got %0d, required 2", commit_cnt - c0);
    end
  endtask

`ifdef BIAS_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    vec_t wv = pack4(8'sd100, 8'sd100, 8'sd100, 8'sd0);
    int   c0;
    int   d0;
    int   e0;
    int   guard = 0;
    send_load(wv, 0, 1'b1);
    wait_done();
    tick();
    send_load(pack4(8'sd1, 8'sd2, 8'sd3, 8'sd4), 0, 1'b1);
    wait_done();
    tick();
    c0 = commit_cnt; d0 = done_cnt; e0 = err_cnt;
    send_load(wv, 0, 1'b0);
    while (err !== 1'b1 && guard < 20) begin tick(); guard++; end
    tick();
    repeat (3) tick();
    n_checks++;
    if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL csum_err_pulse: got %0d, required 1", err_cnt - e0); end
    n_checks++;
    if (commit_cnt != c0 || done_cnt != d0) begin
      n_fail++;
      $display("FAIL csum_no_commit: commits=%0d done=%0d, required 0 0", commit_cnt - c0, done_cnt - d0);
    end
    n_checks++;
    if (dut_vec() !== wv || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL csum_overwrite: vec=%h busy=%b, required %h 0", dut_vec(), busy, wv);
    end
  endtask
`else
  task automatic test_no_checksum();
    n_checks++;
    if (err_cnt != 0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_tied: pulses=%0d err=%b, required 0 0", err_cnt, err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_bubbles();
    test_midload_reset();
    test_start_during_load();
    test_start_held();
`ifdef BIAS_LOADER_CHECKSUM_EN
    test_checksum();
`else
    test_no_checksum();
`endif
    repeat (3) tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_commits: %0d expected commits never seen, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
